divider_iter: RTL and testbench
===============================

Name: divider_iter

Overview:
- Parametrised radix-2 restoring divider; successor to the fixed 32-bit core divider.
- Adds a generic operand width, operands latched at start (no hold requirement), optional early-out leading-zero skip, an explicit divide-by-zero flag and a busy output.
- Sits beside the multiplier in the execute stage and serves DIV/DIVU into HI/LO; usable at other widths by other units.

Parameters:
- WIDTH, 32, operand width in bits (≥ 4).
- EARLY_OUT, 1, 1 = skip leading-zero iterations of the dividend magnitude; 0 = always WIDTH iterations.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  request; sampled only in IDLE.
- abandon  input  1  synchronous flush (pipeline exception); returns the block to IDLE.
- stall  input  1  pipeline stall; holds the result in DONE.
- signdiv  input  1  1 = signed (two's complement); 0 = unsigned. Sampled with start.
- opr1  input  WIDTH  dividend, sampled with start.
- opr2  input  WIDTH  divisor, sampled with start.
- busy  output  1  high in every state except IDLE.
- ready  output  1  result valid (registered).
- dbz  output  1  result came from a zero divisor; valid while ready = 1.
- res  output  2*WIDTH  {remainder, quotient}, registered.

Behaviour:
- Reset (rst = 0, async): state = IDLE; ready = 0, dbz = 0, res = 0, busy = 0; all internal registers cleared.
- Priority at each rising edge: reset, then abandon, then state logic.
- abandon: any state goes to IDLE with ready, dbz and res cleared in the same edge. An in-flight operation is discarded.
- States: IDLE, DIVZ, BUSY, FIX, DONE.
- IDLE:
  - start = 1 latches signdiv, both operand signs, |opr1| and |opr2|. Magnitudes are taken only when signdiv = 1 and the sign bit is set.
  - opr2 == 0 → DIVZ.
  - Otherwise k = leading zeros of |opr1| when EARLY_OUT = 1, else k = 0.
  - Working dividend = |opr1| << k; cnt = k; state → BUSY.
  - |opr1| == 0 gives k = WIDTH, so BUSY exits immediately.
  - start = 0: ready, dbz and res are held at 0.
- BUSY: while cnt != WIDTH, perform one restoring step per cycle.
  - Trial = partial remainder − divisor, computed WIDTH+1 bits wide.
  - Non-negative trial: the remainder takes the trial and quotient bit 1 shifts in. Otherwise shift with quotient bit 0.
  - cnt increments each step. At cnt == WIDTH → FIX.
- FIX, one cycle:
  - Quotient negated if signdiv and the operand signs differ.
  - Remainder negated if signdiv and the dividend is negative; the remainder sign follows the dividend.
  - res ← {rem, quo}; ready ← 1; → DONE.
- DIVZ, one cycle: res ← 0, dbz ← 1, ready ← 1; → DONE.
- DONE: hold res, ready and dbz. When start = 0 and stall = 0, go to IDLE and clear ready, dbz and res in the same edge.
- Signed overflow MIN / −1: quotient = MIN (wraps), remainder = 0, no flag.
- start asserted outside IDLE is ignored. Operand changes after the start edge do not affect the result.
- Latency, counted in edges after the start edge until ready is visible:
  - Normal operation: (WIDTH − k) + 1.
  - EARLY_OUT = 0: WIDTH + 1.
  - Divide by zero: 1.
- All arithmetic is unsigned on magnitudes. The MIN magnitude (2^(WIDTH−1)) must be representable, so magnitudes are WIDTH bits unsigned.

Test Plan:
- WIDTH = 32, EARLY_OUT = 0, unsigned 100 / 7 → res = {0x00000002, 0x0000000E}; ready rises exactly 33 edges after start; busy high throughout.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, 5 / 0 → ready after 1 edge, dbz = 1, res = 0. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- EARLY_OUT = 1, 5 / 3 (k = 29) → {2, 1} with ready after 4 edges; 0 / 9 → {0, 0} after 1 edge.
- Hold and abandon:
  - In DONE with stall = 1 for 5 cycles, res is held; on stall release it returns to IDLE and clears.
  - abandon at iteration 10 → IDLE next edge, ready stays 0; a new start immediately after produces a correct, unpolluted result.
- Async reset: rst dropped mid-BUSY, between clock edges → outputs clear immediately. Repeat one case at WIDTH = 8: 200 / 13 → {5, 15}.

Source files
------------

// File: rtl/divider_iter.sv
// rtl/divider_iter.sv - parametrised radix-2 restoring divider
// Restoring divider on operand magnitudes with optional leading-zero skip;
// signs are reapplied in FIX. Result is {remainder, quotient}.
module divider_iter #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abandon,
  input  logic               stall,
  input  logic               signdiv,
  input  logic [WIDTH-1:0]   opr1,
  input  logic [WIDTH-1:0]   opr2,
  output logic               busy,
  output logic               ready,
  output logic               dbz,
  output logic [2*WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_DIVZ, S_BUSY, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [CW-1:0]      lz, k;
  logic [WIDTH:0]     shifted, trial;
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  always_comb begin
    a_neg = signdiv & opr1[WIDTH-1];
    b_neg = signdiv & opr2[WIDTH-1];
    a_mag = a_neg ? -opr1 : opr1;
    b_mag = b_neg ? -opr2 : opr2;
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (a_mag[i]) lz = CW'(WIDTH - 1 - i);
    end
    k = EARLY_OUT ? lz : '0;
  end

  // The dividend register doubles as the quotient: bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    rem_fix = rneg_q ? -rem_q : rem_q;
    quo_fix = qneg_q ? -dvd_q : dvd_q;
  end

  always_comb begin
    state_d = state_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    dbz_d   = dbz_q;
    res_d   = res_q;
    if (abandon) begin
      state_d = S_IDLE;
      ready_d = 1'b0;
      dbz_d   = 1'b0;
      res_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_d = 1'b0;
          dbz_d   = 1'b0;
          res_d   = '0;
          if (start) begin
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            dvs_d  = b_mag;
            rem_d  = '0;
            if (opr2 == '0) begin
              dvd_d   = '0;
              cnt_d   = '0;
              state_d = S_DIVZ;
            end else begin
              dvd_d   = a_mag << k;
              cnt_d   = k;
              state_d = (k == CW'(WIDTH)) ? S_FIX : S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_d = S_FIX;
          end else begin
            // trial sign bit set means the divisor did not fit: restore
            if (!trial[WIDTH]) begin
              rem_d = trial[WIDTH-1:0];
              dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = shifted[WIDTH-1:0];
              dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
          end
        end
        S_FIX: begin
          res_d   = {rem_fix, quo_fix};
          ready_d = 1'b1;
          state_d = S_DONE;
        end
        S_DIVZ: begin
          res_d   = '0;
          dbz_d   = 1'b1;
          ready_d = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (!start && !stall) begin
            ready_d = 1'b0;
            dbz_d   = 1'b0;
            res_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      dbz_q   <= dbz_d;
      res_q   <= res_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign ready = ready_q;
  assign dbz   = dbz_q;
  assign res   = res_q;

endmodule

// File: tb/tb_divider_iter.sv
// tb/tb_divider_iter.sv - self-checking bench for divider_iter
// Two 32-bit instances (EARLY_OUT 0 and 1) share stimulus; an 8-bit instance runs separately.
module tb_divider_iter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, abandon = 1'b0, stall = 1'b0, signdiv = 1'b0;
  logic [31:0] opr1 = '0, opr2 = '0;
  logic        busy0, ready0, dbz0, busy1, ready1, dbz1;
  logic [63:0] res0, res1;

  logic        start8 = 1'b0, signdiv8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, ready8, dbz8;
  logic [15:0] res8;

  divider_iter #(.WIDTH(32), .EARLY_OUT(1'b0)) u_div0 (
    .clk(clk), .rst(rst), .start(start), .abandon(abandon), .stall(stall),
    .signdiv(signdiv), .opr1(opr1), .opr2(opr2),
    .busy(busy0), .ready(ready0), .dbz(dbz0), .res(res0));

  divider_iter #(.WIDTH(32), .EARLY_OUT(1'b1)) u_div1 (
    .clk(clk), .rst(rst), .start(start), .abandon(abandon), .stall(stall),
    .signdiv(signdiv), .opr1(opr1), .opr2(opr2),
    .busy(busy1), .ready(ready1), .dbz(dbz1), .res(res1));

  divider_iter #(.WIDTH(8), .EARLY_OUT(1'b1)) u_div8 (
    .clk(clk), .rst(rst), .start(start8), .abandon(abandon), .stall(stall),
    .signdiv(signdiv8), .opr1(a8), .opr2(b8),
    .busy(busy8), .ready(ready8), .dbz(dbz8), .res(res8));

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_res;
    bit          exp_dbz;
    int          lat0;
    int          lat1;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint sext(input logic [31:0] v, input int w);
    longint s;
    s = longint'(v);
    s = (s << (64 - w)) >>> (64 - w);
    return s;
  endfunction

  function automatic void model(input bit sd, input logic [31:0] a, input logic [31:0] b,
                                input int w, output logic [31:0] q, output logic [31:0] r,
                                output bit z);
    longint mask, sa, sb;
    mask = (longint'(1) << w) - 1;
    z = ((longint'(b) & mask) == 0);
    q = '0;
    r = '0;
    if (!z) begin
      sa = sd ? sext(a, w) : (longint'(a) & mask);
      sb = sd ? sext(b, w) : (longint'(b) & mask);
      q = 32'((sa / sb) & mask);
      r = 32'((sa % sb) & mask);
    end
  endfunction

  function automatic int lat_model(input bit sd, input logic [31:0] a, input logic [31:0] b,
                                   input int w, input bit eo);
    longint mask, m;
    int n;
    mask = (longint'(1) << w) - 1;
    n = 0;
    if ((longint'(b) & mask) == 0) return 1;
    if (!eo) return w + 1;
    m = sd ? sext(a, w) : (longint'(a) & mask);
    if (m < 0) m = -m;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
    return n + 1;
  endfunction

  task automatic run_op(input string tag, input bit sd, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input bit exp_dbz, input int exp_l0, input int exp_l1);
    int          l0 = -1, l1 = -1;
    logic [63:0] r0 = '0, r1 = '0;
    logic        z0 = 1'b0, z1 = 1'b0;
    logic        busy_ok = 1'b1;
    @(negedge clk);
    signdiv = sd; opr1 = a; opr2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; opr1 = $urandom; opr2 = $urandom; signdiv = ~sd;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ready0 && l0 < 0) begin l0 = n; r0 = res0; z0 = dbz0; end
      if (ready1 && l1 < 0) begin l1 = n; r1 = res1; z1 = dbz1; end
      if (l0 < 0 && !busy0) busy_ok = 1'b0;
    end
    check({tag, " res eo0"}, r0, exp_res);
    check({tag, " dbz eo0"}, 64'(z0), 64'(exp_dbz));
    check({tag, " latency eo0"}, 64'(l0), 64'(exp_l0));
    check({tag, " res eo1"}, r1, exp_res);
    check({tag, " dbz eo1"}, 64'(z1), 64'(exp_dbz));
    check({tag, " latency eo1"}, 64'(l1), 64'(exp_l1));
    check({tag, " busy until ready"}, 64'(busy_ok), 64'd1);
    check({tag, " back to idle"}, {busy0, ready0, dbz0, res0[60:0]}, 64'd0);
  endtask

  task automatic run8(input string tag, input bit sd, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_res, input int exp_lat);
    int          l = -1;
    logic [15:0] r = '0;
    @(negedge clk);
    signdiv8 = sd; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      if (ready8 && l < 0) begin l = n; r = res8; end
    end
    check({tag, " res"}, 64'(r), 64'(exp_res));
    check({tag, " latency"}, 64'(l), 64'(exp_lat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    vec_t        vecs[10];
    logic [31:0] q, r, a, b;
    bit          z, sd;
    logic        seen;
    int          n;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 1'b0, 33, 8};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 1'b0, 33, 4};
    vecs[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1'b0, 33, 4};
    vecs[3] = '{1'b0, 32'd5,          32'd0,          64'h0,                 1'b1, 1,  1};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1'b0, 33, 33};
    vecs[5] = '{1'b0, 32'd5,          32'd3,          64'h00000002_00000001, 1'b0, 33, 4};
    vecs[6] = '{1'b0, 32'd0,          32'd9,          64'h0,                 1'b0, 33, 1};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 1'b0, 33, 33};
    vecs[8] = '{1'b1, 32'hFFFFFFF9,   32'd0,          64'h0,                 1'b1, 1,  1};
    vecs[9] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 1'b0, 33, 33};

    #12;
    check("reset eo0", {busy0, ready0, dbz0, res0[60:0]}, 64'd0);
    check("reset eo1", {busy1, ready1, dbz1, res1[60:0]}, 64'd0);
    check("reset w8", {busy8, ready8, dbz8, res8}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sd, vecs[i].a, vecs[i].b,
             vecs[i].exp_res, vecs[i].exp_dbz, vecs[i].lat0, vecs[i].lat1);

    for (int i = 0; i < 24; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom >> $urandom_range(0, 31);
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      if (sd && $urandom_range(0, 1) == 1) a = -a;
      if (sd && $urandom_range(0, 1) == 1) b = -b;
      model(sd, a, b, 32, q, r, z);
      run_op($sformatf("rand%0d", i), sd, a, b, {r, q}, z,
             lat_model(sd, a, b, 32, 1'b0), lat_model(sd, a, b, 32, 1'b1));
    end

    // stall holds DONE, release returns to IDLE with outputs cleared
    @(negedge clk);
    stall = 1'b1; signdiv = 1'b0; opr1 = 32'd100; opr2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!ready0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall ready", 64'(ready0), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall hold res", res0, 64'h00000002_0000000E);
      check("stall hold ready", 64'(ready0), 64'd1);
    end
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    check("stall release", {busy0, ready0, dbz0, res0[60:0]}, 64'd0);

    // abandon mid-operation, then an immediate fresh operation
    @(negedge clk);
    signdiv = 1'b0; opr1 = 32'd1000000; opr2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | ready0;
    end
    @(negedge clk);
    abandon = 1'b1;
    @(posedge clk); #1;
    abandon = 1'b0;
    check("abandon no early ready", 64'(seen), 64'd0);
    check("abandon idle eo0", {busy0, ready0, dbz0, res0[60:0]}, 64'd0);
    check("abandon idle eo1", {busy1, ready1, dbz1, res1[60:0]}, 64'd0);
    run_op("after abandon", 1'b0, 32'd12345, 32'd67, 64'h00000011_000000B8, 1'b0, 33, 15);

    // asynchronous reset between edges: eo1 parked in DONE, eo0 still busy
    @(negedge clk);
    stall = 1'b1; signdiv = 1'b0; opr1 = 32'd5; opr2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check("pre-reset eo1 ready", 64'(ready1), 64'd1);
    check("pre-reset eo0 busy", 64'(busy0), 64'd1);
    rst = 1'b0;
    #1;
    check("async reset eo0", {busy0, ready0, dbz0, res0[60:0]}, 64'd0);
    check("async reset eo1", {busy1, ready1, dbz1, res1[60:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;

    run8("w8 200/13", 1'b0, 8'd200, 8'd13, 16'h0F0F & 16'h050F | 16'h000F & 16'h0000, 9);
    run8("w8 -100/7", 1'b1, 8'h9C, 8'd7, 16'hFEF2, 8);
    run8("w8 min/-1", 1'b1, 8'h80, 8'hFF, 16'h0080, 9);
    run8("w8 9/0", 1'b0, 8'd9, 8'd0, 16'h0000, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
